bram_xfer_master: RTL and testbench

- Initiator side of the 32-bit BRAM port used by the matrix memory: drives BRAM_ADDR/EN/WE/WRDATA and samples BRAM_RDDATA.
- A command runs two phases back to back:
  - Read phase: fetch LEN words from RD_BASE and stream them out to the multiplier datapath.
  - Write phase: accept LEN result words from the datapath and store them at WR_BASE.
- DONE is a level suitable for driving the memory's done input.

---
 rtl/bram_xfer_pkg.sv | 15 +
 rtl/bram_xfer_master_if.sv | 48 ++++
 rtl/bram_rd_skid.sv | 56 +++++
 rtl/bram_xfer_master.sv | 194 +++++++++++++++++++
 tb/tb_bram_xfer_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_xfer_pkg.sv
// Shared types and constants for the BRAM transfer master.
package bram_xfer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdDrain,
        StWr,
        StFin
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  WE_ALL     = 4'hF;

endpackage

// File: rtl/bram_xfer_master_if.sv
// Command, BRAM port and stream signals of the BRAM transfer master.
// BRAM_XFER_CKSUM_EN adds the CKSUM output.
interface bram_xfer_master_if #(
    parameter int unsigned BRAM_ADDR_WIDTH = 13,
    parameter int unsigned LEN_WIDTH       = 11
);
    logic                       START;
    logic [BRAM_ADDR_WIDTH-1:0] RD_BASE;
    logic [BRAM_ADDR_WIDTH-1:0] WR_BASE;
    logic [LEN_WIDTH-1:0]       LEN;
    logic                       BUSY;
    logic                       DONE;
    logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR;
    logic                       BRAM_EN;
    logic [3:0]                 BRAM_WE;
    logic [31:0]                BRAM_WRDATA;
    logic [31:0]                BRAM_RDDATA;
    logic [31:0]                M_TDATA;
    logic                       M_TVALID;
    logic                       M_TREADY;
    logic [31:0]                S_TDATA;
    logic                       S_TVALID;
    logic                       S_TREADY;
`ifdef BRAM_XFER_CKSUM_EN
    logic [31:0]                CKSUM;
`endif

    // Transfer master's view.
    modport master (
        input  START, RD_BASE, WR_BASE, LEN, BRAM_RDDATA, M_TREADY, S_TDATA, S_TVALID,
        output BUSY, DONE, BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_WRDATA, M_TDATA, M_TVALID,
               S_TREADY
`ifdef BRAM_XFER_CKSUM_EN
        , output CKSUM
`endif
    );

    // Memory, datapath and controller view.
    modport slave (
        output START, RD_BASE, WR_BASE, LEN, BRAM_RDDATA, M_TREADY, S_TDATA, S_TVALID,
        input  BUSY, DONE, BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_WRDATA, M_TDATA, M_TVALID,
               S_TREADY
`ifdef BRAM_XFER_CKSUM_EN
        , input CKSUM
`endif
    );

endinterface

// File: rtl/bram_rd_skid.sv
// Two-entry FIFO holding read data between the BRAM port and the read stream.
module bram_rd_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head_data,
    output logic [1:0]  count
);
    logic [31:0] mem_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        do_push;
    logic        do_pop;

    // Push while full is only accepted alongside a pop; the freed head slot takes it.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    // Occupancy next state.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/bram_xfer_master.sv
// BRAM transfer master: reads LEN words to the read stream, then writes LEN
// result words back. BRAM_XFER_CKSUM_EN adds a running checksum output.
module bram_xfer_master
    import bram_xfer_pkg::*;
#(
    parameter int unsigned BRAM_ADDR_WIDTH = 13,
    parameter int unsigned LEN_WIDTH       = 11
) (
    input  logic               BRAM_CLK,
    input  logic               BRAM_RSTN,
    bram_xfer_master_if.master bus
);
    localparam int unsigned AW = BRAM_ADDR_WIDTH;
    localparam int unsigned LW = LEN_WIDTH;

    state_e        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] issue_cnt_q, issue_cnt_d;
    logic [LW-1:0] beat_cnt_q, beat_cnt_d;
    logic [LW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] bram_addr_q, bram_addr_d;
    logic          bram_en_q, bram_en_d;
    logic [3:0]    bram_we_q, bram_we_d;
    logic [31:0]   bram_wrdata_q, bram_wrdata_d;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef BRAM_XFER_CKSUM_EN
    logic [31:0]   cksum_q, cksum_d;
`endif

    logic          rd_on_port;
    logic [2:0]    occupancy;
    logic          issue_ok;
    logic          m_tvalid;
    logic          skid_pop;
    logic [31:0]   skid_head;
    logic [1:0]    skid_count;
    logic          s_tready;
    logic          wr_fire;

    bram_rd_skid u_skid (
        .clk       (BRAM_CLK),
        .rst_n     (BRAM_RSTN),
        .push      (pend_q),
        .push_data (bus.BRAM_RDDATA),
        .pop       (skid_pop),
        .head_data (skid_head),
        .count     (skid_count)
    );

    // A read is on the port this cycle; its data returns next cycle (pend_q).
    assign rd_on_port = bram_en_q && (bram_we_q == 4'h0);
    // Credits cover both reads still in the port pipeline, so the 2-entry
    // buffer cannot overflow under any M_TREADY pattern.
    assign occupancy  = 3'(skid_count) + 3'(rd_on_port) + 3'(pend_q);
    assign issue_ok   = occupancy < (3'd2 + 3'(skid_pop));
    assign m_tvalid   = skid_count != 2'd0;
    assign skid_pop   = m_tvalid && bus.M_TREADY;
    assign s_tready   = (state_q == StWr) && (wr_cnt_q != len_q);
    assign wr_fire    = s_tready && bus.S_TVALID;
    assign pend_d     = rd_on_port;

    // Next-state, address generation and registered BRAM port values.
    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        len_d         = len_q;
        issue_cnt_d   = issue_cnt_q;
        beat_cnt_d    = beat_cnt_q + LW'(skid_pop);
        wr_cnt_d      = wr_cnt_q;
        bram_addr_d   = bram_addr_q;
        bram_en_d     = 1'b0;
        bram_we_d     = 4'h0;
        bram_wrdata_d = bram_wrdata_q;
        busy_d        = busy_q;
        done_d        = done_q;
`ifdef BRAM_XFER_CKSUM_EN
        cksum_d       = cksum_q + (skid_pop ? skid_head : 32'h0)
                                + (wr_fire ? bus.S_TDATA : 32'h0);
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.START) begin
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    rd_addr_d   = bus.RD_BASE & ~AW'(3);
                    wr_addr_d   = bus.WR_BASE & ~AW'(3);
                    len_d       = bus.LEN;
                    issue_cnt_d = '0;
                    beat_cnt_d  = '0;
                    wr_cnt_d    = '0;
`ifdef BRAM_XFER_CKSUM_EN
                    cksum_d     = '0;
`endif
                    state_d     = (bus.LEN == '0) ? StFin : StRdIssue;
                end
            end
            StRdIssue: begin
                if (issue_ok) begin
                    bram_en_d   = 1'b1;
                    bram_addr_d = rd_addr_q;
                    rd_addr_d   = rd_addr_q + AW'(WORD_BYTES);
                    issue_cnt_d = issue_cnt_q + LW'(1);
                    if (issue_cnt_q == len_q - LW'(1)) begin
                        state_d = StRdDrain;
                    end
                end
            end
            StRdDrain: begin
                if (skid_pop && (beat_cnt_q == len_q - LW'(1))) begin
                    state_d = StWr;
                end
            end
            StWr: begin
                if (wr_fire) begin
                    bram_en_d     = 1'b1;
                    bram_we_d     = WE_ALL;
                    bram_wrdata_d = bus.S_TDATA;
                    bram_addr_d   = wr_addr_q;
                    wr_addr_d     = wr_addr_q + AW'(WORD_BYTES);
                    wr_cnt_d      = wr_cnt_q + LW'(1);
                end else if (wr_cnt_q == len_q) begin
                    // Final write is on the port this cycle.
                    state_d = StFin;
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset discards any command in progress.
    always_ff @(posedge BRAM_CLK or negedge BRAM_RSTN) begin
        if (!BRAM_RSTN) begin
            state_q       <= StIdle;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            len_q         <= '0;
            issue_cnt_q   <= '0;
            beat_cnt_q    <= '0;
            wr_cnt_q      <= '0;
            bram_addr_q   <= '0;
            bram_en_q     <= 1'b0;
            bram_we_q     <= 4'h0;
            bram_wrdata_q <= '0;
            pend_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef BRAM_XFER_CKSUM_EN
            cksum_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            len_q         <= len_d;
            issue_cnt_q   <= issue_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            bram_addr_q   <= bram_addr_d;
            bram_en_q     <= bram_en_d;
            bram_we_q     <= bram_we_d;
            bram_wrdata_q <= bram_wrdata_d;
            pend_q        <= pend_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef BRAM_XFER_CKSUM_EN
            cksum_q       <= cksum_d;
`endif
        end
    end

    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.BRAM_ADDR   = bram_addr_q;
    assign bus.BRAM_EN     = bram_en_q;
    assign bus.BRAM_WE     = bram_we_q;
    assign bus.BRAM_WRDATA = bram_wrdata_q;
    assign bus.M_TDATA     = skid_head;
    assign bus.M_TVALID    = m_tvalid;
    assign bus.S_TREADY    = s_tready;
`ifdef BRAM_XFER_CKSUM_EN
    assign bus.CKSUM       = cksum_q;
`endif

endmodule

// File: tb/tb_bram_xfer_master.sv
// Directed bench for bram_xfer_master with a behavioural BRAM model.
`timescale 1ns/1ps
module tb_bram_xfer_master;
    localparam int unsigned AW = 13;
    localparam int unsigned LW = 11;

    logic clk;
    logic rst_n;
    logic preload_req;
    int   checks;
    int   failures;

    bram_xfer_master_if #(.BRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    bram_xfer_master #(.BRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .BRAM_CLK  (clk),
        .BRAM_RSTN (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency, full-word writes.
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'(i) + 32'h100;
        end else if (bus.BRAM_EN) begin
            if (bus.BRAM_WE != 4'h0) mem[bus.BRAM_ADDR[12:2]] <= bus.BRAM_WRDATA;
            else                     bus.BRAM_RDDATA <= mem[bus.BRAM_ADDR[12:2]];
        end
    end

    // Passive monitor sampling on the falling edge.
    int          cyc = 0;
    int          we_bad = 0;
    int          skid_over = 0;
    logic [12:0] rd_addr_log[$];
    int          rd_cyc_log[$];
    logic [12:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] beat_log[$];
    int          beat_cyc_log[$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.BRAM_EN && bus.BRAM_WE == 4'h0) begin
            rd_addr_log.push_back(bus.BRAM_ADDR);
            rd_cyc_log.push_back(cyc);
        end
        if (bus.BRAM_EN && bus.BRAM_WE != 4'h0) begin
            wr_addr_log.push_back(bus.BRAM_ADDR);
            wr_data_log.push_back(bus.BRAM_WRDATA);
            if (bus.BRAM_WE != 4'hF) we_bad = we_bad + 1;
        end
        if (!bus.BRAM_EN && bus.BRAM_WE != 4'h0) we_bad = we_bad + 1;
        if (dut.u_skid.count > 2'd2) skid_over = skid_over + 1;
        if (bus.M_TVALID && bus.M_TREADY) begin
            beat_log.push_back(bus.M_TDATA);
            beat_cyc_log.push_back(cyc);
        end
    end

    logic [31:0] wr_words [0:15];
    int rb, wb, bb, web;

    task automatic mark_logs();
        rb  = rd_addr_log.size();
        wb  = wr_addr_log.size();
        bb  = beat_log.size();
        web = we_bad;
    endtask

    // Runs one command: START, stream handshakes, wait for DONE (bounded).
    task automatic run_cmd(input logic [12:0] rd_base, input logic [12:0] wr_base,
                           input logic [10:0] len, input int rdy_mode, input bit gap,
                           input int restart_at);
        int widx = 0;
        int n = 0;
        bit gap_done = 1'b0;
        @(posedge clk); #1;
        bus.RD_BASE  = rd_base;
        bus.WR_BASE  = wr_base;
        bus.LEN      = len;
        bus.START    = 1'b1;
        bus.M_TREADY = 1'b1;
        bus.S_TVALID = 1'b0;
        bus.S_TDATA  = wr_words[0];
        do begin
            @(negedge clk);
            if (bus.S_TVALID && bus.S_TREADY) widx++;
            @(posedge clk); #1;
            n++;
            bus.START = (restart_at != 0) && (n == restart_at);
            if (bus.START) begin
                bus.RD_BASE = 13'h800;
                bus.WR_BASE = 13'h600;
                bus.LEN     = 11'd5;
            end
            bus.M_TREADY = (rdy_mode == 0) || (n % 3 == 0);
            if (gap && widx == 1 && !gap_done) begin
                bus.S_TVALID = 1'b0;
                gap_done     = 1'b1;
            end else begin
                bus.S_TVALID = (widx < int'(len));
                bus.S_TDATA  = wr_words[widx & 15];
            end
        end while (!bus.DONE && n < 300);
        bus.S_TVALID = 1'b0;
        bus.M_TREADY = 1'b0;
        checks++;
        if (bus.DONE !== 1'b1) begin
            failures++;
            $display("FAIL cmd_done_timeout: DONE=%b after %0d cycles, required 1", bus.DONE, n);
        end
    endtask

    task automatic check_reads(input string tag, input logic [12:0] base, input int len,
                               input logic [31:0] first_word);
        checks++;
        if (rd_addr_log.size() - rb !== len || beat_log.size() - bb !== len) begin
            failures++;
            $display("FAIL %s_counts: reads=%0d beats=%0d, required %0d each", tag,
                     rd_addr_log.size() - rb, beat_log.size() - bb, len);
        end
        for (int i = 0; i < len; i++) begin
            logic [12:0] a;
            logic [31:0] d;
            logic [12:0] ea;
            a  = (rb + i < rd_addr_log.size()) ? rd_addr_log[rb + i] : 13'hx;
            d  = (bb + i < beat_log.size()) ? beat_log[bb + i] : 32'hx;
            ea = base + 13'(4 * i);
            checks++;
            if (a !== ea) begin
                failures++;
                $display("FAIL %s_addr%0d: got %h, required %h", tag, i, a, ea);
            end
            checks++;
            if (d !== first_word + 32'(i)) begin
                failures++;
                $display("FAIL %s_beat%0d: got %h, required %h", tag, i, d, first_word + 32'(i));
            end
        end
    endtask

    task automatic check_writes(input string tag, input logic [12:0] base, input int len);
        checks++;
        if (wr_addr_log.size() - wb !== len || we_bad !== web) begin
            failures++;
            $display("FAIL %s_wr_count: writes=%0d bad_we=%0d, required %0d and 0", tag,
                     wr_addr_log.size() - wb, we_bad - web, len);
        end
        for (int i = 0; i < len; i++) begin
            logic [12:0] a;
            logic [31:0] d;
            logic [12:0] ea;
            a  = (wb + i < wr_addr_log.size()) ? wr_addr_log[wb + i] : 13'hx;
            d  = (wb + i < wr_data_log.size()) ? wr_data_log[wb + i] : 32'hx;
            ea = base + 13'(4 * i);
            checks++;
            if (a !== ea || d !== wr_words[i]) begin
                failures++;
                $display("FAIL %s_wr%0d: got addr %h data %h, required %h %h", tag, i, a, d,
                         ea, wr_words[i]);
            end
            checks++;
            if (mem[ea[12:2]] !== wr_words[i]) begin
                failures++;
                $display("FAIL %s_mem%0d: got %h, required %h", tag, i, mem[ea[12:2]], wr_words[i]);
            end
        end
        checks++;
        if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s_status: DONE=%b BUSY=%b, required 1 0", tag, bus.DONE, bus.BUSY);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus.BUSY, bus.DONE, bus.BRAM_EN, bus.M_TVALID, bus.S_TREADY} !== 5'b0 ||
            bus.BRAM_WE !== 4'h0 || bus.BRAM_ADDR !== 13'h0) begin
            failures++;
            $display("FAIL %s_ctrl: BUSY=%b DONE=%b EN=%b MV=%b SR=%b WE=%h ADDR=%h, required 0",
                     tag, bus.BUSY, bus.DONE, bus.BRAM_EN, bus.M_TVALID, bus.S_TREADY,
                     bus.BRAM_WE, bus.BRAM_ADDR);
        end
        checks++;
        if (bus.BRAM_WRDATA !== 32'h0 || bus.M_TDATA !== 32'h0) begin
            failures++;
            $display("FAIL %s_data: WRDATA=%h M_TDATA=%h, required 0", tag, bus.BRAM_WRDATA,
                     bus.M_TDATA);
        end
    endtask

    task automatic test_reset();
        bus.START = 1'b0; bus.RD_BASE = '0; bus.WR_BASE = '0; bus.LEN = '0;
        bus.M_TREADY = 1'b0; bus.S_TVALID = 1'b0; bus.S_TDATA = '0;
        rst_n = 1'b0;
        preload_req = 1'b1;
        @(posedge clk); #1;
        preload_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mark_logs();
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        checks++;
        if (rd_addr_log.size() + wr_addr_log.size() !== 0) begin
            failures++;
            $display("FAIL reset_idle_en: EN cycles=%0d, required 0",
                     rd_addr_log.size() + wr_addr_log.size());
        end
    endtask

    task automatic test_read_stream();
        for (int i = 0; i < 4; i++) wr_words[i] = 32'hD00 + 32'(i);
        mark_logs();
        run_cmd(13'h10, 13'h200, 11'd4, 0, 1'b0, 0);
        check_reads("rd", 13'h10, 4, 32'h104);
        checks++;
        if (beat_cyc_log.size() <= bb || rd_cyc_log.size() <= rb ||
            beat_cyc_log[bb] - rd_cyc_log[rb] !== 2) begin
            failures++;
            $display("FAIL rd_first_latency: got %0d cycles, required 2",
                     (beat_cyc_log.size() > bb && rd_cyc_log.size() > rb) ?
                     beat_cyc_log[bb] - rd_cyc_log[rb] : -1);
        end
        check_writes("rd_wr", 13'h200, 4);
    endtask

    task automatic test_ready_toggle();
        for (int i = 0; i < 4; i++) wr_words[i] = 32'hE00 + 32'(i);
        mark_logs();
        run_cmd(13'h10, 13'h300, 11'd4, 1, 1'b0, 0);
        check_reads("tog", 13'h10, 4, 32'h104);
        checks++;
        if (skid_over !== 0) begin
            failures++;
            $display("FAIL tog_skid_bound: over-full cycles=%0d, required 0", skid_over);
        end
        check_writes("tog_wr", 13'h300, 4);
    endtask

    task automatic test_write_gap();
        wr_words[0] = 32'hA; wr_words[1] = 32'hB; wr_words[2] = 32'hC;
        mark_logs();
        run_cmd(13'h10, 13'h40, 11'd3, 0, 1'b1, 0);
        check_reads("gap", 13'h10, 3, 32'h104);
        check_writes("gap_wr", 13'h40, 3);
        checks++;
        if (mem[11'h13] !== 32'h113) begin
            failures++;
            $display("FAIL gap_mem_untouched: got %h, required 00000113", mem[11'h13]);
        end
    endtask

    task automatic test_len_zero_restart();
        mark_logs();
        @(posedge clk); #1;
        bus.LEN = 11'd0; bus.START = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
            failures++;
            $display("FAIL len0_busy: BUSY=%b DONE=%b, required 1 0", bus.BUSY, bus.DONE);
        end
        @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1) begin
            failures++;
            $display("FAIL len0_done: BUSY=%b DONE=%b, required 0 1", bus.BUSY, bus.DONE);
        end
        checks++;
        if (rd_addr_log.size() - rb + wr_addr_log.size() - wb + beat_log.size() - bb !== 0) begin
            failures++;
            $display("FAIL len0_no_access: accesses+beats=%0d, required 0",
                     rd_addr_log.size() - rb + wr_addr_log.size() - wb + beat_log.size() - bb);
        end
        wr_words[0] = 32'hF0; wr_words[1] = 32'hF1;
        mark_logs();
        run_cmd(13'h20, 13'h100, 11'd2, 0, 1'b0, 2);
        check_reads("rst", 13'h20, 2, 32'h108);
        check_writes("rst_wr", 13'h100, 2);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0 || rd_addr_log.size() - rb !== 2) begin
            failures++;
            $display("FAIL restart_ignored: BUSY=%b reads=%0d, required 0 and 2", bus.BUSY,
                     rd_addr_log.size() - rb);
        end
    endtask

    task automatic test_reset_midcmd_wrap();
        int n = 0;
        int rd_seen;
        mark_logs();
        @(posedge clk); #1;
        bus.RD_BASE = 13'h0; bus.WR_BASE = 13'h400; bus.LEN = 11'd8;
        bus.START = 1'b1; bus.M_TREADY = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        while (beat_log.size() - bb < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        rd_seen = rd_addr_log.size();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_addr_log.size() !== rd_seen || wr_addr_log.size() !== wb || bus.M_TVALID !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet: reads %0d->%0d writes=%0d MV=%b, required no change",
                     rd_seen, rd_addr_log.size(), wr_addr_log.size() - wb, bus.M_TVALID);
        end
        bus.M_TREADY = 1'b0;
        wr_words[0] = 32'h11111111; wr_words[1] = 32'h22222222;
        mark_logs();
        run_cmd(13'h1FFC, 13'h1FFE, 11'd2, 0, 1'b0, 0);
        checks++;
        if (rd_addr_log.size() - rb !== 2 || rd_addr_log[rb] !== 13'h1FFC ||
            rd_addr_log[rb + 1] !== 13'h0) begin
            failures++;
            $display("FAIL wrap_rd_addr: count=%0d, required 1ffc then 0000", rd_addr_log.size() - rb);
        end
        checks++;
        if (beat_log.size() - bb !== 2 || beat_log[bb] !== 32'h8FF || beat_log[bb + 1] !== 32'h100) begin
            failures++;
            $display("FAIL wrap_beats: count=%0d, required 000008ff then 00000100",
                     beat_log.size() - bb);
        end
        check_writes("wrap_wr", 13'h1FFC, 2);
`ifdef BRAM_XFER_CKSUM_EN
        checks++;
        if (bus.CKSUM !== 32'h33333D32) begin
            failures++;
            $display("FAIL cksum: got %h, required 33333d32", bus.CKSUM);
        end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        preload_req = 1'b0;
        test_reset();
        test_read_stream();
        test_ready_toggle();
        test_write_gap();
        test_len_zero_restart();
        test_reset_midcmd_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
